iob_prescaler: RTL and testbench
================================

// Module: iob_prescaler
// PURPOSE
//  Programmable tick generator directly upstream of iob_counter: tick_o drives counter_en_i.
//  - One tick every DIV+1 enabled cycles.
//  - Start/stop control.
//  - Glitch-free divisor reload through a valid/ready shadow register.
//  - Used wherever the design needs a timebase slower than clk_i, e.g. timeouts and IFG timing.
// PARAMETERS
//  DATA_W   16  width of divisor and internal down-counter
//  RST_DIV  0   divisor value after reset (DATA_W bits)
// PORTS
//  clk_i        in   1       clock; one clock domain, all logic on rising edge
//  cke_i        in   1       clock enable; when 0, all registers hold and tick_o=0
//  rst_i        in   1       reset, synchronous, active-high
//  div_i        in   DATA_W  new divisor (period = div_i+1 cycles)
//  div_valid_i  in   1       div_i valid; accepted when div_valid_i & div_ready_o
//  div_ready_o  out  1       0 while a shadowed divisor is pending
//  start_i      in   1       start periodic ticking
//  stop_i       in   1       stop ticking, return to IDLE
//  busy_o       out  1       1 when state != IDLE
//  tick_o       out  1       one-cycle enable pulse; connects to iob_counter counter_en_i
// BEHAVIOUR
//  Reset
//  - rst_i=1 at an edge gives state=IDLE, cnt=0, div_r=RST_DIV, shadow=0, pending=0.
//  - Outputs after reset: busy_o=0, tick_o=0, div_ready_o=1.
//  - Reset mid-run aborts immediately; no tick in the cycle after the reset edge.
//  - rst_i overrides cke_i.
//  States
//  - IDLE: no ticks. start_i=1 -> RUN, cnt<=div_r.
//  - RUN: if cnt==0 then tick and cnt<=reload, else cnt<=cnt-1. stop_i=1 -> IDLE.
//  Output logic
//  - tick_o = (state==RUN) & (cnt==0) & cke_i; combinational from registers only.
//  - Timing: start_i high in cycle T gives the first tick in cycle T+1+div_r, then one tick every div_r+1 cycles.
//  - div_r=0 gives tick_o continuously high from T+1.
//  - Down-counter only, no overflow possible; cnt never wraps below 0.
//  Start/stop
//  - start_i while in RUN is ignored; the phase is not restarted.
//  - start_i and stop_i high in the same cycle: stop wins.
//  - From IDLE the state stays IDLE; from RUN it goes to IDLE.
//  - stop_i in cycle S: a tick due in cycle S is still emitted; state is IDLE from S+1.
//  Divisor handshake
//  - In IDLE, an accepted div_i is written to div_r at that edge; pending stays 0.
//  - In RUN, an accepted div_i goes to shadow and sets pending=1, so div_ready_o=0 from the next cycle.
//  - On the next tick: reload = shadow, div_r<=shadow, pending<=0.
//  - Load accepted in the same cycle as a tick: bypass. That reload uses div_i, div_r<=div_i, pending stays 0.
//  - Stop with pending=1: div_r<=shadow, pending<=0 on the IDLE transition.
//  - Without pending or bypass: reload = div_r.
//  - div_ready_o = ~pending; it does not depend combinationally on div_valid_i.
//  Clock enable
//  - cke_i=0 freezes state, cnt, div_r, shadow and pending.
//  - A handshake is not accepted while cke_i=0.
// CONFIGURATION
//  IOB_PRESCALER_ONESHOT_EN
//  - Defined: adds input oneshot_i (1 bit), sampled with start_i.
//  - If start_i & oneshot_i: exactly one tick at T+1+div_r, then state=IDLE from the following cycle.
//  - The one-shot flag clears on stop/reset.
//  - Not defined: no oneshot_i port; RUN is always periodic.
// STRUCTURE
//  - Shared include iob_prescaler_conf.vh holds:
//    - IOB_PRESCALER_DATA_W, IOB_PRESCALER_RST_DIV defaults;
//    - state encoding localparams IDLE=1'b0, RUN=1'b1.
//  - Sub-module iob_prescaler_shadow: div_r/shadow/pending registers, handshake and bypass logic.
//    - Outputs the reload value and div_ready_o.
//  - Top level holds the FSM and down-counter.
// TESTING
//  1 Reset: rst_i=1 for 2 cycles with RST_DIV=3 -> busy_o=0, tick_o=0, div_ready_o=1; start -> ticks every 4 cycles.
//  2 Period: load div_i=4 in IDLE, start at T -> tick_o at T+5, T+10, T+15; each tick 1 cycle wide.
//  3 div=0: load 0, start at T -> tick_o high every cycle from T+1 until stop; stop at S -> tick_o=0 from S+1.
//  4 Shadow reload: div_r=9 running, load div_i=2 mid-period.
//    - div_ready_o=0 until the next tick; then the period is 3.
//    - A second load while pending is not accepted.
//  5 Corners:
//    - start+stop in the same cycle -> IDLE.
//    - Load in a tick cycle -> immediate bypass, period = new div+1.
//    - cke_i=0 for 3 cycles mid-run -> the next tick is delayed by exactly 3.
//  6 IOB_PRESCALER_ONESHOT_EN: div=6, start+oneshot at T -> a single tick at T+7, busy_o=0 from T+8.
//    - Without the macro: the build has no oneshot_i port and test 2 behaviour holds.

Source files
------------

// File: rtl/iob_prescaler_pkg.sv
// iob_prescaler_pkg: build defaults and FSM state encoding shared by the prescaler files
package iob_prescaler_pkg;
    localparam int IOB_PRESCALER_DATA_W = 16;
    localparam int IOB_PRESCALER_RST_DIV = 0;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/iob_prescaler_shadow.sv
// iob_prescaler_shadow: divisor register, shadow/pending handshake and same-cycle bypass
module iob_prescaler_shadow #(
    parameter int DATA_W  = 16,
    parameter int RST_DIV = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cke_i,
    input  logic              run_i,
    input  logic              tick_i,
    input  logic              stop_i,
    input  logic [DATA_W-1:0] div_i,
    input  logic              div_valid_i,
    output logic              div_ready_o,
    output logic [DATA_W-1:0] reload_o
);
    logic [DATA_W-1:0] div_r_q, div_r_d, shadow_q, shadow_d;
    logic              pend_q, pend_d, accept, commit;
    assign accept      = cke_i & div_valid_i & ~pend_q;
    assign div_ready_o = ~pend_q;
    assign reload_o    = accept ? div_i : pend_q ? shadow_q : div_r_q;
    // A new divisor may become active only while idle, at a tick, or when leaving RUN
    assign commit      = ~run_i | tick_i | stop_i;
    always_comb begin
        div_r_d  = commit ? reload_o : div_r_q;
        pend_d   = commit ? 1'b0 : (pend_q | accept);
        shadow_d = (~commit & accept) ? div_i : shadow_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_r_q  <= DATA_W'(RST_DIV);
            shadow_q <= '0;
            pend_q   <= 1'b0;
        end else if (cke_i) begin
            div_r_q  <= div_r_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
        end
    end
endmodule

// File: rtl/iob_prescaler.sv
// iob_prescaler: programmable tick generator; IOB_PRESCALER_ONESHOT_EN adds oneshot_i
module iob_prescaler
    import iob_prescaler_pkg::*;
#(
    parameter int DATA_W  = IOB_PRESCALER_DATA_W,
    parameter int RST_DIV = IOB_PRESCALER_RST_DIV
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] div_i,
    input  logic              div_valid_i,
    output logic              div_ready_o,
    input  logic              start_i,
    input  logic              stop_i,
`ifdef IOB_PRESCALER_ONESHOT_EN
    input  logic              oneshot_i,
`endif
    output logic              busy_o,
    output logic              tick_o
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] cnt_q, cnt_d, reload;
    logic              os_q, os_d, os_in;
`ifdef IOB_PRESCALER_ONESHOT_EN
    assign os_in = oneshot_i;
`else
    assign os_in = 1'b0;
`endif
    assign busy_o = state_q == RUN;
    assign tick_o = (state_q == RUN) & (cnt_q == '0) & cke_i;
    iob_prescaler_shadow #(.DATA_W(DATA_W), .RST_DIV(RST_DIV)) u_shadow (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cke_i       (cke_i),
        .run_i       (state_q == RUN),
        .tick_i      (tick_o),
        .stop_i      (stop_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .reload_o    (reload)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        os_d    = os_q;
        if (state_q == IDLE) begin
            if (start_i & ~stop_i) begin
                state_d = RUN;
                cnt_d   = reload;
                os_d    = os_in;
            end
        end else if (stop_i) begin
            state_d = IDLE;
            os_d    = 1'b0;
        end else if (cnt_q == '0) begin
            cnt_d   = reload;
            state_d = os_q ? IDLE : RUN;
            os_d    = 1'b0;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            os_q    <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            os_q    <= os_d;
        end
    end
endmodule

// File: tb/tb_iob_prescaler.sv
// tb_iob_prescaler: directed self-checking bench for iob_prescaler (RST_DIV=3)
module tb_iob_prescaler;
    logic        clk_i = 0, cke_i = 1, rst_i = 0;
    logic [15:0] div_i = '0;
    logic        div_valid_i = 0, start_i = 0, stop_i = 0, oneshot_i = 0;
    logic        div_ready_o, busy_o, tick_o;
    int          tests = 0, fails = 0;

    always #5 clk_i = ~clk_i;

    iob_prescaler #(.DATA_W(16), .RST_DIV(3)) dut (
        .clk_i       (clk_i),
        .cke_i       (cke_i),
        .rst_i       (rst_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .start_i     (start_i),
        .stop_i      (stop_i),
`ifdef IOB_PRESCALER_ONESHOT_EN
        .oneshot_i   (oneshot_i),
`endif
        .busy_o      (busy_o),
        .tick_o      (tick_o)
    );

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_idle(input logic [15:0] d);
        div_i = d;
        div_valid_i = 1;
        cyc();
        div_valid_i = 0;
    endtask

    task automatic start_run();
        start_i = 1;
        cyc();
        start_i = 0;
    endtask

    task automatic stop_run();
        stop_i = 1;
        cyc();
        stop_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1;
        cyc();
        cyc();
        rst_i = 0;
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        tests++; if (tick_o !== 1'b0) begin fails++; $display("FAIL reset_tick got %b exp 0", tick_o); end
        tests++; if (div_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", div_ready_o); end
        start_run();
        for (int k = 1; k <= 12; k++) begin
            logic exp;
            exp = (k == 4 || k == 8 || k == 12);
            tests++; if (tick_o !== exp) begin fails++; $display("FAIL reset_period k=%0d got %b exp %b", k, tick_o, exp); end
            cyc();
        end
        stop_run();
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_stop_busy got %b exp 0", busy_o); end
    endtask

    task automatic test_period();
        load_idle(16'd4);
        tests++; if (div_ready_o !== 1'b1) begin fails++; $display("FAIL period_ready got %b exp 1", div_ready_o); end
        start_run();
        for (int k = 1; k <= 16; k++) begin
            logic exp;
            exp = (k == 5 || k == 10 || k == 15);
            tests++; if (tick_o !== exp) begin fails++; $display("FAIL period k=%0d got %b exp %b", k, tick_o, exp); end
            cyc();
        end
        stop_run();
    endtask

    task automatic test_div0();
        load_idle(16'd0);
        start_run();
        for (int k = 1; k <= 5; k++) begin
            tests++; if (tick_o !== 1'b1) begin fails++; $display("FAIL div0 k=%0d got %b exp 1", k, tick_o); end
            cyc();
        end
        stop_i = 1;
        tests++; if (tick_o !== 1'b1) begin fails++; $display("FAIL div0_stop_cycle got %b exp 1", tick_o); end
        cyc();
        stop_i = 0;
        tests++; if (tick_o !== 1'b0) begin fails++; $display("FAIL div0_after_stop_tick got %b exp 0", tick_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL div0_after_stop_busy got %b exp 0", busy_o); end
    endtask

    task automatic test_shadow();
        load_idle(16'd9);
        start_run();
        for (int k = 1; k <= 19; k++) begin
            logic exp_t, exp_r;
            div_valid_i = (k == 3 || k == 4);
            div_i = (k == 3) ? 16'd2 : 16'd7;
            exp_t = (k == 10 || k == 13 || k == 16 || k == 19);
            exp_r = (k <= 3 || k >= 11);
            tests++; if (tick_o !== exp_t) begin fails++; $display("FAIL shadow_tick k=%0d got %b exp %b", k, tick_o, exp_t); end
            tests++; if (div_ready_o !== exp_r) begin fails++; $display("FAIL shadow_ready k=%0d got %b exp %b", k, div_ready_o, exp_r); end
            cyc();
        end
        div_valid_i = 0;
        stop_run();
    endtask

    task automatic test_corners();
        start_i = 1;
        stop_i = 1;
        cyc();
        start_i = 0;
        stop_i = 0;
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL start_stop_busy got %b exp 0", busy_o); end
        load_idle(16'd5);
        start_run();
        for (int k = 1; k <= 11; k++) begin
            logic exp;
            div_valid_i = (k == 6);
            div_i = 16'd1;
            exp = (k == 6 || k == 8 || k == 10);
            tests++; if (tick_o !== exp) begin fails++; $display("FAIL bypass k=%0d got %b exp %b", k, tick_o, exp); end
            tests++; if (div_ready_o !== 1'b1) begin fails++; $display("FAIL bypass_ready k=%0d got %b exp 1", k, div_ready_o); end
            cyc();
        end
        div_valid_i = 0;
        stop_run();
        load_idle(16'd4);
        start_run();
        for (int k = 1; k <= 13; k++) begin
            logic exp;
            cke_i = !(k >= 2 && k <= 4);
            exp = (k == 8 || k == 13);
            tests++; if (tick_o !== exp) begin fails++; $display("FAIL cke k=%0d got %b exp %b", k, tick_o, exp); end
            cyc();
        end
        cke_i = 1;
        stop_run();
        load_idle(16'd0);
        start_run();
        tests++; if (tick_o !== 1'b1) begin fails++; $display("FAIL rst_mid_pre got %b exp 1", tick_o); end
        rst_i = 1;
        cyc();
        rst_i = 0;
        tests++; if (tick_o !== 1'b0) begin fails++; $display("FAIL rst_mid_tick got %b exp 0", tick_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b exp 0", busy_o); end
    endtask

`ifdef IOB_PRESCALER_ONESHOT_EN
    task automatic test_oneshot();
        load_idle(16'd6);
        oneshot_i = 1;
        start_run();
        oneshot_i = 0;
        for (int k = 1; k <= 12; k++) begin
            logic exp_t, exp_b;
            exp_t = (k == 7);
            exp_b = (k <= 7);
            tests++; if (tick_o !== exp_t) begin fails++; $display("FAIL oneshot_tick k=%0d got %b exp %b", k, tick_o, exp_t); end
            tests++; if (busy_o !== exp_b) begin fails++; $display("FAIL oneshot_busy k=%0d got %b exp %b", k, busy_o, exp_b); end
            cyc();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_period();
        test_div0();
        test_shadow();
        test_corners();
`ifdef IOB_PRESCALER_ONESHOT_EN
        test_oneshot();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
